// File: rtl/apb3_pkg.sv
// rtl/apb3_pkg.sv - shared types and constants for the APB3 round-robin master
// Contents: FSM state encoding, state enum, default bus timeout.
package apb3_pkg;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_SETUP_ENC  = 2'd1;
  localparam logic [1:0] ST_ACCESS_ENC = 2'd2;

  localparam int DEFAULT_TIMEOUT = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_SETUP  = ST_SETUP_ENC,
    ST_ACCESS = ST_ACCESS_ENC
  } apb3_state_t;

endpackage

// File: rtl/apb3_rr_master_if.sv
// rtl/apb3_rr_master_if.sv - APB3 bus interface with host and slave views
// Ports (host view): psel, penable, pwrite, paddr, pwdata out; prdata, pready, pslverr in.
interface apb3_intf #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AWIDTH-1:0] paddr;
  logic [DWIDTH-1:0] pwdata;
  logic [DWIDTH-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport host (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb3_rr_master_rr_arbiter.sv
// rtl/apb3_rr_master_rr_arbiter.sv - round-robin arbiter with owned rotation pointer
// Ports: clk, rst (sync, active-high); req[N] in; advance in (commit current grant);
//        gnt_onehot[N], gnt_idx, any out (combinational from req and pointer).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;

  // Search starts at the pointer and wraps modulo N; first requester found wins.
  always_comb begin
    logic [IW-1:0] j;
    j          = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_idx       = j;
        gnt_onehot[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/apb3_rr_master.sv
// rtl/apb3_rr_master.sv - shares one APB3 host port among NREQ requesters, round-robin
// Ports: clk, rst (sync, active-high);
//        req_valid/req_ready/req_write [NREQ], req_addr [NREQ*AWIDTH], req_wdata [NREQ*DWIDTH];
//        rsp_valid [NREQ] one-cycle pulse, rsp_rdata, rsp_err (valid with rsp_valid);
//        apb: apb3_intf host modport.
module apb3_rr_master
  import apb3_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*AWIDTH-1:0] req_addr,
  input  logic [NREQ*DWIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_rdata,
  output logic                   rsp_err,
  apb3_intf.host                 apb
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  apb3_state_t       state;
  logic [IW-1:0]     owner;
  logic [CW-1:0]     tcnt;

  logic [NREQ-1:0]   gnt_onehot;
  logic [IW-1:0]     gnt_idx;
  logic              any;
  logic              grant_en;
  logic              timeout_hit;
  logic [NREQ-1:0]   owner_oh;
  logic [AWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0] sel_wdata;
  logic              sel_write;

  // A new command may be taken only with the bus free or on the completing ACCESS
  // cycle; reset blocks grants so a command is never lost into a resetting FSM.
  assign grant_en  = !rst && ((state == ST_IDLE) || (state == ST_ACCESS && apb.pready));
  assign req_ready = grant_en ? gnt_onehot : '0;

  // Timeout only fires on a cycle the slave is still stalling, so pready always wins.
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == CW'(TIMEOUT - 1)) && !apb.pready;

  assign owner_oh = NREQ'(1) << owner;

  always_comb begin
    sel_addr  = req_addr[int'(gnt_idx)*AWIDTH +: AWIDTH];
    sel_wdata = req_wdata[int'(gnt_idx)*DWIDTH +: DWIDTH];
    sel_write = req_write[gnt_idx];
  end

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .advance    (grant_en && any),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= '0;
      tcnt        <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.pwrite  <= 1'b0;
      apb.paddr   <= '0;
      apb.pwdata  <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (any) begin
            apb.paddr   <= sel_addr;
            apb.pwrite  <= sel_write;
            apb.pwdata  <= sel_wdata;
            owner       <= gnt_idx;
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          apb.penable <= 1'b1;
          tcnt        <= '0;
          state       <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (apb.pready) begin
            rsp_valid <= owner_oh;
            rsp_rdata <= apb.prdata;
            rsp_err   <= apb.pslverr;
            if (any) begin
              // Back-to-back: psel stays high, next command goes straight to SETUP.
              apb.paddr   <= sel_addr;
              apb.pwrite  <= sel_write;
              apb.pwdata  <= sel_wdata;
              owner       <= gnt_idx;
              apb.penable <= 1'b0;
              state       <= ST_SETUP;
            end else begin
              apb.psel    <= 1'b0;
              apb.penable <= 1'b0;
              state       <= ST_IDLE;
            end
          end else if (timeout_hit) begin
            rsp_valid   <= owner_oh;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: begin
          apb.psel    <= 1'b0;
          apb.penable <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb3_rr_master.sv
// tb/tb_apb3_rr_master.sv - scoreboard bench for apb3_rr_master
module tb_apb3_rr_master;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;

  apb3_intf #(.AWIDTH(AW), .DWIDTH(DW)) apb ();

  apb3_rr_master #(.NREQ(N), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .apb       (apb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          g;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          w;
    int          gcyc;
  } plan_t;

  typedef struct {
    int          g;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  plan_t plan_q[$];
  rsp_t  exp_q[$];
  plan_t cur;

  int tests = 0;
  int fails = 0;
  int ptr = 0;
  int next_grant = 0;
  int scnt = 0;
  bit s_act = 0;
  int mode = 0;  // 0: clear on grant, 1: re-issue on grant, 2: random traffic
  bit fz = 0;
  bit f_en = 0;
  int f_w = 0;
  logic [31:0] f_rd = '0;
  logic f_err = 1'b0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic new_cmd(input int i);
    req_write[i]          = 1'($urandom);
    req_addr[i*AW +: AW]  = $urandom & 32'h0000_0FFC;
    req_wdata[i*DW +: DW] = $urandom;
    req_valid[i]          = 1'b1;
  endtask

  task automatic issue(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]          = 1'b1;
  endtask

  task automatic do_cycle();
    int g;
    int r;
    bit rst_was;
    bit exp_setup;
    logic [1:0] exp_bus;
    logic [N-1:0] exp_oh;
    plan_t p;
    rsp_t e;
    @(negedge clk);
    g = -1;
    rst_was = rst;
    if (rst) begin
      chk("ready_in_reset", 96'(req_ready), 96'(0));
    end else begin
      exp_setup = (plan_q.size() > 0) && (plan_q[0].gcyc == cyc - 1);
      exp_bus = exp_setup ? 2'b10 : (s_act ? 2'b11 : 2'b00);
      chk("bus_phase", 96'({apb.psel, apb.penable}), 96'(exp_bus));
      if (s_act) begin
        chk("access_hold", {apb.pwrite, apb.paddr, apb.pwdata}, {cur.wr, cur.addr, cur.wdata});
        if (apb.pready || scnt == TO - 1) s_act = 0;
        else scnt++;
      end
      if (exp_setup) begin
        cur = plan_q.pop_front();
        chk("setup_cmd", {apb.pwrite, apb.paddr, apb.pwdata}, {cur.wr, cur.addr, cur.wdata});
        s_act = 1;
        scnt = 0;
      end
      if (req_valid != 0 && cyc >= next_grant) g = rr_pick(req_valid, ptr);
      exp_oh = (g >= 0) ? (N'(1) << g) : '0;
      chk("grant", 96'(req_ready), 96'(exp_oh));
      if (g >= 0) begin
        p.g     = g;
        p.wr    = req_write[g];
        p.addr  = req_addr[g*AW +: AW];
        p.wdata = req_wdata[g*DW +: DW];
        p.gcyc  = cyc;
        if (f_en) begin
          p.w = f_w; p.rd = f_rd; p.err = f_err; f_en = 0;
        end else begin
          r = $urandom % 16;
          p.w   = fz ? 0 : (r < 2 ? 8 + $urandom % 3 : (r == 2 ? 7 : $urandom % 4));
          p.rd  = $urandom;
          p.err = ($urandom % 8 == 0);
        end
        plan_q.push_back(p);
        e.g = g;
        if (p.w < TO) begin
          e.rdata = p.rd; e.err = p.err; e.cyc = cyc + 3 + p.w; next_grant = cyc + 2 + p.w;
        end else begin
          e.rdata = '0; e.err = 1'b1; e.cyc = cyc + 2 + TO; next_grant = cyc + 2 + TO;
        end
        exp_q.push_back(e);
        ptr = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    if (rst_was) begin
      plan_q.delete();
      exp_q.delete();
      s_act = 0;
      ptr = 0;
      next_grant = 0;
    end
    apb.pready  = s_act && (scnt == cur.w);
    apb.prdata  = apb.pready ? cur.rd : $urandom;
    apb.pslverr = apb.pready ? cur.err : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == g) begin
        req_valid[i] = 1'b0;
        if (mode == 1 || (mode == 2 && $urandom % 4 != 0)) new_cmd(i);
      end else if (mode == 2) begin
        if (!req_valid[i] && $urandom % 3 == 0) new_cmd(i);
        else if (req_valid[i] && $urandom % 32 == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    mode = 0;
    while ((plan_q.size() > 0 || exp_q.size() > 0 || s_act || req_valid != 0) && k < 300) begin
      do_cycle();
      k++;
    end
    if (k >= 300) chk("drain_bound", 96'(1), 96'(0));
    do_cycle();
  endtask

  // Response monitor: pops the scoreboard whenever the DUT pulses rsp_valid.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rsp_valid != 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 96'(rsp_valid), 96'(0));
          end else begin
            e = exp_q.pop_front();
            chk("rsp_valid", 96'(rsp_valid), 96'(N'(1) << e.g));
            chk("rsp_data", {63'(0), rsp_err, rsp_rdata}, {63'(0), e.err, e.rdata});
            chk("rsp_cycle", 96'(cyc), 96'(e.cyc));
          end
        end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          chk("missing_rsp", 96'(0), 96'(exp_q[0].cyc));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    apb.prdata = '0; apb.pready = 1'b0; apb.pslverr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_bus", {apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata}, 96'(0));
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single read from requester 2, zero wait states.
    f_en = 1; f_w = 0; f_rd = 32'hDEAD_BEEF; f_err = 0;
    issue(2, 1'b0, 32'h40, 32'h0);
    drain();

    // Write from requester 1 with three wait states.
    f_en = 1; f_w = 3; f_rd = 32'h0; f_err = 0;
    issue(1, 1'b1, 32'h10, 32'h1234_5678);
    drain();

    // Read with slave error.
    f_en = 1; f_w = 0; f_rd = 32'h5555_AAAA; f_err = 1;
    issue(0, 1'b0, 32'h20, 32'h0);
    drain();

    // Stalled slave times out; requester 0 waits and is served afterwards.
    f_en = 1; f_w = 100; f_rd = 32'hFFFF_FFFF; f_err = 0;
    issue(3, 1'b0, 32'h30, 32'h0);
    issue(0, 1'b1, 32'h34, 32'hCAFE_F00D);
    drain();

    // All requesters held valid, zero wait states.
    fz = 1;
    for (int i = 0; i < N; i++) new_cmd(i);
    mode = 1;
    repeat (12) do_cycle();
    fz = 0;
    req_valid = '0;
    drain();

    // Random traffic.
    mode = 2;
    repeat (1500) do_cycle();
    drain();

    // Reset in the middle of ACCESS: transfer discarded, pointer back to 0.
    f_en = 1; f_w = 100; f_rd = 32'h0; f_err = 0;
    issue(2, 1'b0, 32'h80, 32'h0);
    repeat (5) do_cycle();
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
    f_en = 0;
    issue(1, 1'b0, 32'h84, 32'h0);
    issue(0, 1'b0, 32'h88, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
